// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared AXIS widths, helpers and the default {tlast, tdata} entry type
package axis_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int ADDR_W  = addr_w(DEPTH_DEF);
    localparam int LEVEL_W = level_w(DEPTH_DEF);

    typedef struct packed {
        logic                  tlast;
        logic [DATA_W_DEF-1:0] tdata;
    } axis_entry_t;

endpackage

// File: rtl/axis_fifo_mem.sv
// rtl/axis_fifo_mem.sv - DEPTH x W register array, one write port, asynchronous read port
module axis_fifo_mem #(
    parameter int W     = 9,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// rtl/axis_pkt_fifo.sv - AXI4-Stream FIFO with optional store-and-forward packet release
module axis_pkt_fifo
    import axis_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int PKT_MODE = 0
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [DATA_W-1:0]            s_axis_tdata,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic [DATA_W-1:0]            m_axis_tdata,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = addr_w(DEPTH);
    localparam int LW = level_w(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_q, level_nxt;
    logic [LW-1:0] pkt_cnt, pkt_nxt;
    logic          rdy_q;
    logic          push, pop;
    logic [DATA_W:0] rd_entry;

    assign push = s_axis_tvalid & rdy_q;
    assign pop  = m_axis_tvalid & m_axis_tready;

    always_comb begin
        level_nxt = level_q;
        case ({push, pop})
            2'b10:   level_nxt = level_q + LW'(1);
            2'b01:   level_nxt = level_q - LW'(1);
            default: level_nxt = level_q;
        endcase
    end

    always_comb begin
        pkt_nxt = pkt_cnt;
        case ({push & s_axis_tlast, pop & m_axis_tlast})
            2'b10:   pkt_nxt = pkt_cnt + LW'(1);
            2'b01:   pkt_nxt = pkt_cnt - LW'(1);
            default: pkt_nxt = pkt_cnt;
        endcase
    end

    // tready is registered from next level so downstream tready never reaches upstream combinationally
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            pkt_cnt <= '0;
            rdy_q   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level_q <= level_nxt;
            pkt_cnt <= pkt_nxt;
            rdy_q   <= (level_nxt != FULL_LVL);
        end
    end

    axis_fifo_mem #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .aclk    (aclk),
        .aresetn (aresetn),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data ({s_axis_tlast, s_axis_tdata}),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

    // Full buffer releases even without a stored tlast so oversize packets cannot deadlock
    assign m_axis_tvalid = (level_q != '0) &&
                           ((PKT_MODE == 0) || (pkt_cnt != '0) || (level_q == FULL_LVL));
    assign m_axis_tlast  = rd_entry[DATA_W];
    assign m_axis_tdata  = rd_entry[DATA_W-1:0];
    assign s_axis_tready = rdy_q;
    assign level         = level_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// tb/tb_axis_pkt_fifo.sv - directed self-checking bench for stream and packet modes
module tb_axis_pkt_fifo;

    logic       aclk = 1'b0;
    logic       aresetn;

    logic [7:0] s0_data, m0_data, s1_data, m1_data;
    logic       s0_valid, s0_last, s0_ready, m0_valid, m0_last, m0_ready;
    logic       s1_valid, s1_last, s1_ready, m1_valid, m1_last, m1_ready;
    logic [2:0] lvl0, lvl1;

    int pass_cnt = 0;
    int total    = 0;

    always #5 aclk = ~aclk;

    axis_pkt_fifo #(.DATA_W(8), .DEPTH(4), .PKT_MODE(0)) dut0 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s0_data), .s_axis_tvalid(s0_valid), .s_axis_tlast(s0_last), .s_axis_tready(s0_ready),
        .m_axis_tdata(m0_data), .m_axis_tvalid(m0_valid), .m_axis_tlast(m0_last), .m_axis_tready(m0_ready),
        .level(lvl0)
    );

    axis_pkt_fifo #(.DATA_W(8), .DEPTH(4), .PKT_MODE(1)) dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s1_data), .s_axis_tvalid(s1_valid), .s_axis_tlast(s1_last), .s_axis_tready(s1_ready),
        .m_axis_tdata(m1_data), .m_axis_tvalid(m1_valid), .m_axis_tlast(m1_last), .m_axis_tready(m1_ready),
        .level(lvl1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [7:0] d, input logic l);
        s0_valid = v; s0_data = d; s0_last = l;
    endtask

    task automatic drive1(input logic v, input logic [7:0] d, input logic l);
        s1_valid = v; s1_data = d; s1_last = l;
    endtask

    initial begin
        int idx_in, idx_out, cyc;
        logic do_push;

        aresetn = 1'b0;
        drive0(0, 8'h00, 0); drive1(0, 8'h00, 0);
        m0_ready = 1'b1; m1_ready = 1'b1;
        #2;
        check("rst_tvalid", m0_valid, 0);
        check("rst_tdata",  m0_data, 0);
        check("rst_tlast",  m0_last, 0);
        check("rst_level",  lvl0, 0);
        check("rst_tready", s0_ready, 0);
        tick(); tick();
        aresetn = 1'b1;
        tick();
        check("tready_after_rst", s0_ready, 1);

        // stream mode: 1-cycle latency, consecutive outputs
        drive0(1, 8'h11, 0); tick();
        check("st_v0", m0_valid, 1); check("st_d0", m0_data, 8'h11); check("st_l0", m0_last, 0);
        drive0(1, 8'h22, 0); tick();
        check("st_d1", m0_data, 8'h22); check("st_l1", m0_last, 0); check("st_lvl1", lvl0, 1);
        drive0(1, 8'h33, 1); tick();
        check("st_d2", m0_data, 8'h33); check("st_l2", m0_last, 1);
        drive0(0, 8'h00, 0); tick();
        check("st_empty_v", m0_valid, 0); check("st_empty_lvl", lvl0, 0);

        // fill / backpressure
        m0_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive0(1, 8'(i), 0); tick();
        end
        check("full_lvl", lvl0, 4); check("full_rdy", s0_ready, 0);
        drive0(1, 8'h05, 0); tick();
        check("stall_lvl", lvl0, 4); check("stall_head", m0_data, 8'h01);
        m0_ready = 1'b1; tick();
        check("bp_d02", m0_data, 8'h02); check("bp_lvl3", lvl0, 3); check("bp_rdy", s0_ready, 1);
        tick();
        check("bp_d03", m0_data, 8'h03); check("bp_lvl3b", lvl0, 3);
        drive0(0, 8'h00, 0); tick();
        check("bp_d04", m0_data, 8'h04);
        tick();
        check("bp_d05", m0_data, 8'h05); check("bp_lvl1", lvl0, 1);
        tick();
        check("bp_empty", m0_valid, 0); check("bp_lvl0", lvl0, 0);

        // simultaneous push/pop at level 2
        m0_ready = 1'b0;
        drive0(1, 8'h40, 0); tick();
        drive0(1, 8'h41, 0); tick();
        check("sim_lvl_start", lvl0, 2);
        m0_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive0(1, 8'(8'h42 + i), 0); tick();
            check("sim_lvl", lvl0, 2);
            check("sim_data", m0_data, 32'(8'h41 + i));
        end
        drive0(0, 8'h00, 0); tick();
        check("sim_tail", m0_data, 8'h4B); check("sim_tail_lvl", lvl0, 1);
        tick();
        check("sim_drained", lvl0, 0);

        // packet mode: hold until tlast stored
        drive1(1, 8'hA0, 0); tick();
        check("pk_hold0", m1_valid, 0); check("pk_lvl1", lvl1, 1);
        drive1(1, 8'hA1, 0); tick();
        check("pk_hold1", m1_valid, 0);
        drive1(1, 8'hA2, 1); tick();
        check("pk_v0", m1_valid, 1); check("pk_d0", m1_data, 8'hA0); check("pk_l0", m1_last, 0);
        drive1(0, 8'h00, 0); tick();
        check("pk_d1", m1_data, 8'hA1); check("pk_l1", m1_last, 0);
        tick();
        check("pk_d2", m1_data, 8'hA2); check("pk_l2", m1_last, 1);
        tick();
        check("pk_empty", m1_valid, 0); check("pk_lvl0", lvl1, 0);

        // packet mode: oversize 6-beat packet escapes through a full buffer
        idx_in = 0; idx_out = 0; cyc = 0;
        while (idx_out < 6 && cyc < 60) begin
            if (idx_in < 6) drive1(1, 8'(8'hB0 + idx_in), (idx_in == 5));
            else            drive1(0, 8'h00, 0);
            do_push = s1_valid & s1_ready;
            if (m1_valid) begin
                if (idx_out == 0) check("ov_first_lvl", lvl1, 4);
                check("ov_data", m1_data, 32'(8'hB0 + idx_out));
                check("ov_last", m1_last, (idx_out == 5));
                idx_out++;
            end
            if (do_push) idx_in++;
            tick();
            cyc++;
        end
        check("ov_all_delivered", idx_out, 6);
        drive1(0, 8'h00, 0);
        check("ov_lvl0", lvl1, 0);

        // reset mid-operation
        m0_ready = 1'b0;
        drive0(1, 8'hC1, 0); tick();
        drive0(1, 8'hC2, 0); tick();
        drive0(1, 8'hC3, 0); tick();
        drive0(0, 8'h00, 0);
        check("pre_rst_lvl", lvl0, 3);
        aresetn = 1'b0;
        #1;
        check("mid_rst_v", m0_valid, 0); check("mid_rst_lvl", lvl0, 0);
        check("mid_rst_d", m0_data, 0); check("mid_rst_rdy", s0_ready, 0);
        tick();
        aresetn = 1'b1;
        m0_ready = 1'b1;
        tick();
        check("post_rst_v", m0_valid, 0); check("post_rst_rdy", s0_ready, 1);
        drive0(1, 8'h5A, 0); tick();
        drive0(0, 8'h00, 0);
        check("post_rst_first_v", m0_valid, 1); check("post_rst_first_d", m0_data, 8'h5A);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/axis_pkt_fifo.md
# axis_pkt_fifo

Parametrised AXI4-Stream buffer with tdata/tlast, configurable data width and depth, and an optional store-and-forward packet mode. Sits between AXIS producers and consumers in the streaming datapath, replacing single-entry register slices where more elasticity or whole-packet release is needed. Full throughput (one beat per cycle in and out simultaneously), no combinational path from m_axis_tready to s_axis_tready.

## Interface
- DATA_W, 8, tdata width in bits (≥1)
- DEPTH, 4, number of entries; power of two, ≥2
- PKT_MODE, 0, 0 = stream (cut-through) mode; 1 = hold output until a complete packet (tlast) is stored
- aclk  in  1  clock, all state on rising edge
- aresetn  in  1  reset, asynchronous, active-low
- s_axis_tdata  in  DATA_W  input beat data
- s_axis_tvalid  in  1  input beat valid
- s_axis_tlast  in  1  input end-of-packet marker
- s_axis_tready  out  1  buffer can accept a beat
- m_axis_tdata  out  DATA_W  output beat data
- m_axis_tvalid  out  1  output beat valid
- m_axis_tlast  out  1  output end-of-packet marker
- m_axis_tready  in  1  downstream accepts beat
- level  out  $clog2(DEPTH+1)  number of stored beats

## Operation
- Push = s_axis_tvalid & s_axis_tready; pop = m_axis_tvalid & m_axis_tready.
- Storage: DEPTH entries of {tlast, tdata}; write pointer and read pointer, each $clog2(DEPTH) bits, wrap from DEPTH-1 to 0.
- level: +1 on push only, −1 on pop only, unchanged on both or neither. Never exceeds DEPTH, never below 0.
- s_axis_tready = (level != DEPTH) and not in reset. Depends only on registered state.
- pkt_cnt (internal, $clog2(DEPTH+1) bits): +1 on push with s_axis_tlast=1, −1 on pop with m_axis_tlast=1, unchanged if both.
- m_axis_tvalid: PKT_MODE=0 → level != 0. PKT_MODE=1 → level != 0 and (pkt_cnt != 0 or level == DEPTH). The level == DEPTH clause is the oversize-packet escape: a packet longer than DEPTH drains cut-through instead of deadlocking.
- m_axis_tdata/m_axis_tlast = entry at read pointer, driven from registered storage. Held stable while m_axis_tvalid=1 and m_axis_tready=0.
- Empty: pop impossible (tvalid=0); push still allowed. Full: push impossible; pop allowed, s_axis_tready rises the cycle after the pop.
- Simultaneous push and pop when full is impossible (tready=0). Simultaneous push and pop otherwise: both take effect, level unchanged.

## Timing
- Reset (aresetn low, asynchronous): pointers, level, pkt_cnt = 0; all storage entries = 0; m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, level=0, s_axis_tready=0. s_axis_tready=1 from the first edge after release.
- Reset mid-packet: all stored beats are discarded, no partial output afterwards.
- Latency, PKT_MODE=0: beat pushed at edge k appears on m_axis with tvalid=1 after edge k (visible in cycle k+1) if the buffer was empty.
- Latency, PKT_MODE=1: first beat of a packet is valid the cycle after its tlast beat is pushed (or the cycle after level reaches DEPTH).
- Sustained throughput: 1 beat/cycle when both sides are continuously ready.

## Structure
- Shared package axis_pkg: localparams for address width ($clog2(DEPTH)) and level width ($clog2(DEPTH+1)), and the {tlast, tdata} entry typedef, reused by later AXIS blocks.
- One sub-module, axis_fifo_mem: DEPTH×(DATA_W+1) register array, one write port, one asynchronous read port, reset to 0.
- Top holds pointers, level, pkt_cnt and the handshake logic.

## Test plan
- Stream mode, DEPTH=4: push 0x11,0x22,0x33 (tlast on 0x33) with m_axis_tready=1 → outputs 0x11,0x22,0x33 in consecutive cycles, 1-cycle latency, tlast only on 0x33.
- Fill/backpressure: m_axis_tready=0, push 0x01..0x05 → 0x01..0x04 accepted, level=4, s_axis_tready=0 stalls 0x05. Release tready → order 0x01..0x05 preserved, level returns to 0.
- Simultaneous push/pop at level=2 for 10 cycles → level stays 2, no beat lost or duplicated.
- PKT_MODE=1: push 0xA0,0xA1 (no tlast), m_axis_tready=1 → m_axis_tvalid stays 0. Push 0xA2 with tlast → next cycle 0xA0 valid, then 0xA1, then 0xA2 with tlast.
- PKT_MODE=1 oversize: 6-beat packet, DEPTH=4 → output starts when level=4, all 6 beats delivered in order.
- Reset mid-operation: assert aresetn low at level=3 → next cycle m_axis_tvalid=0, level=0, m_axis_tdata=0. After release, new beat 0x5A is the first output.
